// File: rtl/ex_muldiv_seq_if.sv
// ex_muldiv_seq_if: request/response bundle between the EX stage and the M-extension sequencer.
// master (EX stage) drives start, flush, funct3, data1, data2 and receives stall, done, result.
// slave (sequencer) is the mirror image.
interface ex_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, flush, funct3, data1, data2,
    input  stall, done, result
  );

  modport slave (
    input  start, flush, funct3, data1, data2,
    output stall, done, result
  );
endinterface

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: multi-cycle RV32M multiply/divide sequencer on one shared radix-2 shift/add-sub datapath.
// Latency: done pulses WIDTH+1 cycles after accept; 1 cycle for div-by-zero/signed overflow when EARLY_OUT=1.
// Backpressure: stall holds the pipeline from accept until the result is delivered; start in CALC is ignored.
// Ports: clk; rst (async, active-high); bus (slave modport): start, flush, funct3, data1, data2 in;
//        stall (combinational), done (registered pulse), result (registered) out.
module ex_muldiv_seq #(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input logic            clk,
  input logic            rst,
  ex_muldiv_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int               CW      = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CW-1:0]    count;
  logic [2:0]       op;
  logic [WIDTH:0]   acc;     // product high half, or partial remainder
  logic [WIDTH-1:0] lo;      // multiplier shifting out / dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] opb;     // |multiplicand| or |divisor|
  logic             neg_q;   // negate product / quotient
  logic             neg_r;   // negate remainder (dividend sign)
  logic             done_q;
  logic [WIDTH-1:0] res_q;

  // Accept-time decode
  logic             accept, is_div, sgn_a, sgn_b, neg_a, neg_b, b_zero, ovf, early;
  logic [WIDTH-1:0] abs_a, abs_b, early_res;

  always_comb begin
    accept = bus.start & ~bus.flush & (state != CALC);
    is_div = bus.funct3[2];
    // MULH, MULHSU and the signed divides treat rs1 as signed; rs2 is signed for MULH and DIV/REM.
    sgn_a  = (bus.funct3 == 3'b001) | (bus.funct3 == 3'b010) | (is_div & ~bus.funct3[0]);
    sgn_b  = (bus.funct3 == 3'b001) | (is_div & ~bus.funct3[0]);
    neg_a  = sgn_a & bus.data1[WIDTH-1];
    neg_b  = sgn_b & bus.data2[WIDTH-1];
    abs_a  = neg_a ? -bus.data1 : bus.data1;
    abs_b  = neg_b ? -bus.data2 : bus.data2;
    b_zero = (bus.data2 == '0);
    ovf    = is_div & ~bus.funct3[0] & (bus.data1 == MIN_NEG) & (bus.data2 == '1);
    early  = EARLY_OUT & is_div & (b_zero | ovf);
    if (b_zero) early_res = bus.funct3[1] ? bus.data1 : '1;
    else        early_res = bus.funct3[1] ? '0 : MIN_NEG;
  end

  // One iteration of the shared datapath plus the final result formatting
  logic [WIDTH:0]     sum, shifted, diff, acc_n;
  logic [WIDTH-1:0]   lo_n, quo_s, rem_s, fin;
  logic [2*WIDTH-1:0] prod, prod_s;

  always_comb begin
    sum     = {1'b0, acc[WIDTH-1:0]} + (lo[0] ? {1'b0, opb} : '0);
    shifted = {acc[WIDTH-1:0], lo[WIDTH-1]};
    diff    = shifted - {1'b0, opb};
    if (op[2]) begin
      if (shifted >= {1'b0, opb}) begin
        acc_n = diff;
        lo_n  = {lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = shifted;
        lo_n  = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_n = {1'b0, sum[WIDTH:1]};
      lo_n  = {sum[0], lo[WIDTH-1:1]};
    end
    prod   = {acc_n[WIDTH-1:0], lo_n};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_n : lo_n;
    rem_s  = neg_r ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
    case (op)
      3'b000:                 fin = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fin = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fin = quo_s;
      default:                fin = rem_s;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      op     <= '0;
      acc    <= '0;
      lo     <= '0;
      opb    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else if (bus.flush) begin
      state  <= IDLE;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          acc   <= acc_n;
          lo    <= lo_n;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            res_q  <= fin;
            done_q <= 1'b1;
            count  <= '0;
            state  <= DONE;
          end
        end
        default: begin  // IDLE or DONE: a new op may be accepted while the old result is delivered
          done_q <= 1'b0;
          state  <= IDLE;
          if (accept) begin
            op    <= bus.funct3;
            count <= '0;
            if (early) begin
              res_q  <= early_res;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              acc   <= '0;
              lo    <= abs_a;
              opb   <= abs_b;
              // A zero divisor must yield an all-ones quotient regardless of the dividend sign.
              neg_q <= (neg_a ^ neg_b) & ~(is_div & b_zero);
              neg_r <= neg_a;
              state <= CALC;
            end
          end
        end
      endcase
    end
  end

  assign bus.stall  = ~rst & ((state == CALC) | accept);
  assign bus.done   = done_q;
  assign bus.result = res_q;
endmodule

// File: tb/tb_ex_muldiv_seq.sv
`timescale 1ns/1ps
module tb_ex_muldiv_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_seq_if #(.WIDTH(32)) bus ();

  ex_muldiv_seq #(.WIDTH(32), .EARLY_OUT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic following the RV32M rules.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = '0;
    case (f3)
      3'd0: p = 64'(ua * ub);
      3'd1: p = 64'(sa * sb) >> 32;
      3'd2: p = 64'(sa * ub) >> 32;
      3'd3: p = 64'(ua * ub) >> 32;
      3'd4: p = (b == 0) ? 64'hFFFF_FFFF : 64'(sa / sb);
      3'd5: p = (b == 0) ? 64'hFFFF_FFFF : 64'(ua / ub);
      3'd6: p = (b == 0) ? {32'd0, a} : 64'(sa % sb);
      default: p = (b == 0) ? {32'd0, a} : 64'(ua % ub);
    endcase
    return p[31:0];
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in the current cycle T and follow it to its done pulse.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat;
    bit stall_ok;
    logic [31:0] got;
    bus.funct3 = f3; bus.data1 = a; bus.data2 = b; bus.start = 1'b1;
    lat = 0; stall_ok = 1'b1;
    @(negedge clk);
    if (bus.stall !== 1'b1) stall_ok = 1'b0;
    do begin
      tick();
      bus.start = 1'b0; bus.funct3 = 3'($urandom); bus.data1 = $urandom; bus.data2 = $urandom;
      lat++;
      @(negedge clk);
      if (!bus.done && bus.stall !== 1'b1) stall_ok = 1'b0;
    end while (!bus.done && lat < 40);
    got = bus.result;
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat(f3, a, b)));
    check({tag, "_res"}, got, model(f3, a, b));
    check({tag, "_stall_busy"}, {31'd0, stall_ok}, 32'd1);
    check({tag, "_stall_done"}, {31'd0, bus.stall}, 32'd0);
    tick();
  endtask

  // Second start held high from the cycle after the first accept through the first DONE.
  task automatic run_b2b(input logic [2:0] f1, input logic [31:0] a1, input logic [31:0] b1,
                         input logic [2:0] f2, input logic [31:0] a2, input logic [31:0] b2);
    int lat1, lat2;
    bus.funct3 = f1; bus.data1 = a1; bus.data2 = b1; bus.start = 1'b1;
    lat1 = 0;
    do begin
      tick();
      bus.funct3 = f2; bus.data1 = a2; bus.data2 = b2;
      lat1++;
      @(negedge clk);
    end while (!bus.done && lat1 < 40);
    check("b2b_lat1", 32'(lat1), 32'(exp_lat(f1, a1, b1)));
    check("b2b_res1", bus.result, model(f1, a1, b1));
    check("b2b_stall_on_accept", {31'd0, bus.stall}, 32'd1);
    lat2 = 0;
    do begin
      tick();
      bus.start = 1'b0; bus.data1 = $urandom; bus.data2 = $urandom;
      lat2++;
      @(negedge clk);
    end while (!bus.done && lat2 < 40);
    check("b2b_lat2", 32'(lat2), 32'(exp_lat(f2, a2, b2)));
    check("b2b_res2", bus.result, model(f2, a2, b2));
    tick();
  endtask

  task automatic expect_no_done(input string tag);
    bit seen;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests);
    $fatal(1);
  end

  initial begin
    logic [2:0]  f, f2;
    logic [31:0] a, b, a2, b2;
    rst = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0; bus.data1 = '0; bus.data2 = '0;
    #12;
    check("reset_stall", {31'd0, bus.stall}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_result", bus.result, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, "mul_7xm3");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh");
    run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, "rem_m7_2");
    run_op(3'd5, 32'd100, 32'd7, "divu_100_7");
    run_op(3'd7, 32'd100, 32'd7, "remu_100_7");
    run_op(3'd4, 32'd5, 32'd0, "div_by0");
    run_op(3'd6, 32'd5, 32'd0, "rem_by0");
    run_op(3'd5, 32'hFFFF_FFF0, 32'd0, "divu_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_op(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, "remu_ovf_ops");

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 15)); end
        3: begin a = -32'($urandom_range(1, 255)); b = -32'($urandom_range(1, 15)); end
        default: ;
      endcase
      run_op(f, a, b, "rnd");
    end

    run_b2b(3'd0, 32'd12345, 32'd678, 3'd5, 32'd1000, 32'd33);
    for (int i = 0; i < 3; i++) begin
      f  = 3'($urandom_range(0, 7)); a  = $urandom; b  = $urandom;
      f2 = 3'($urandom_range(0, 7)); a2 = $urandom; b2 = (i == 2) ? 32'd0 : $urandom;
      run_b2b(f, a, b, f2, a2, b2);
    end

    // Flush at T+10 of a DIVU
    bus.funct3 = 3'd5; bus.data1 = 32'd100; bus.data2 = 32'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_stall_t10", {31'd0, bus.stall}, 32'd1);
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_stall_t11", {31'd0, bus.stall}, 32'd0);
    expect_no_done("flush_no_done");

    // Flush wins over start in the same cycle
    bus.funct3 = 3'd0; bus.data1 = 32'd3; bus.data2 = 32'd4; bus.start = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    check("flush_start_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    expect_no_done("flush_start_no_done");

    // Reset in the middle of CALC, with a nonzero result left from the previous op
    run_op(3'd5, 32'd100, 32'd7, "pre_rst_divu");
    bus.funct3 = 3'd0; bus.data1 = 32'd9; bus.data2 = 32'd9; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    check("rst_pre_stall", {31'd0, bus.stall}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_mid_done", {31'd0, bus.done}, 32'd0);
    check("rst_mid_result", bus.result, 32'd0);
    tick();
    rst = 1'b0;
    expect_no_done("rst_no_done");
    run_op(3'd1, 32'h7FFF_FFFF, 32'h8000_0000, "post_rst_mulh");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
